// File: rtl/dt_pkg.sv
// Shared types and geometry for the distance-transform packer: FSM states,
// image/word dimensions and address widths.
package dt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int IMG_W     = 128;
  localparam int IMG_H     = 128;
  localparam int WORD_BITS = 16;
  localparam int RES_AW    = 14;
  localparam int STI_AW    = 10;
  localparam int CNT_W     = 5;

  localparam logic [STI_AW-1:0] LAST_WORD = 10'd1023;
  localparam logic [CNT_W-1:0]  CNT_LAST  = 5'd16;

endpackage

// File: rtl/dt_pack_shreg.sv
// Threshold compare, 16-pixel shift register and max-value tracker.
// Max tracking only exists when DT_PACK_MAXDIST_EN is defined; otherwise max_dist is tied to 0.
module dt_pack_shreg
  import dt_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_acc,
  input  logic [7:0]           thr_in,
  input  logic                 sample_en,
  input  logic [7:0]           res_di,
  output logic [WORD_BITS-1:0] pix_word,
  output logic [7:0]           max_dist
);

  logic [7:0]           thr_q, thr_d;
  logic [WORD_BITS-1:0] sh_q, sh_d;
  logic                 hit;

  assign hit      = (res_di >= thr_q);
  // Word as it will stand after this cycle's sample; captured by the top on the last sample.
  assign pix_word = {sh_q[WORD_BITS-2:0], hit};

  always_comb begin
    thr_d = thr_q;
    sh_d  = sh_q;
    if (start_acc) begin
      thr_d = thr_in;
      sh_d  = '0;
    end else if (sample_en) begin
      sh_d = pix_word;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      thr_q <= '0;
      sh_q  <= '0;
    end else begin
      thr_q <= thr_d;
      sh_q  <= sh_d;
    end
  end

`ifdef DT_PACK_MAXDIST_EN
  logic [7:0] max_q, max_d;

  always_comb begin
    max_d = max_q;
    if (start_acc) begin
      max_d = '0;
    end else if (sample_en && (res_di > max_q)) begin
      max_d = res_di;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max_q <= '0;
    end else begin
      max_q <= max_d;
    end
  end

  assign max_dist = max_q;
`else
  assign max_dist = 8'd0;
`endif

endmodule

// File: rtl/dt_pack.sv
// Binarises a 128x128 result image and packs it 16 pixels per word, 18 cycles per word.
// Optional max-pixel tracking enabled by defining DT_PACK_MAXDIST_EN.
module dt_pack
  import dt_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        thr,
  output logic              res_rd,
  output logic [RES_AW-1:0] res_addr,
  input  logic [7:0]        res_di,
  output logic              sti_wr,
  output logic [STI_AW-1:0] sti_addr,
  output logic [15:0]       sti_do,
  output logic              busy,
  output logic              done,
  output logic [7:0]        max_dist
);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [STI_AW-1:0]     word_q, word_d;
  logic [STI_AW-1:0]     sti_addr_q, sti_addr_d;
  logic [WORD_BITS-1:0]  sti_do_q, sti_do_d;
  logic                  start_acc;
  logic                  sample_en;
  logic [WORD_BITS-1:0]  pix_word;

  // Read data lags the address by one cycle, so samples land on cnt 1..16.
  assign sample_en = (state_q == ST_RD) && (cnt_q != '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    sti_addr_d = sti_addr_q;
    sti_do_d   = sti_do_q;
    start_acc  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RD;
          cnt_d     = '0;
          word_d    = '0;
          start_acc = 1'b1;
        end
      end
      ST_RD: begin
        if (cnt_q == CNT_LAST) begin
          state_d    = ST_WR;
          cnt_d      = '0;
          sti_addr_d = word_q;
          sti_do_d   = pix_word;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      ST_WR: begin
        if (word_q == LAST_WORD) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RD;
          word_d  = word_q + 10'd1;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      word_q     <= '0;
      sti_addr_q <= '0;
      sti_do_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      sti_addr_q <= sti_addr_d;
      sti_do_q   <= sti_do_d;
    end
  end

  assign res_rd   = (state_q == ST_RD) && !cnt_q[CNT_W-1];
  assign res_addr = {word_q, cnt_q[3:0]};
  assign sti_wr   = (state_q == ST_WR);
  assign sti_addr = sti_addr_q;
  assign sti_do   = sti_do_q;
  assign busy     = (state_q == ST_RD) || (state_q == ST_WR);
  assign done     = (state_q == ST_DONE);

  dt_pack_shreg u_shreg (
    .clk       (clk),
    .reset     (reset),
    .start_acc (start_acc),
    .thr_in    (thr),
    .sample_en (sample_en),
    .res_di    (res_di),
    .pix_word  (pix_word),
    .max_dist  (max_dist)
  );

endmodule

// File: tb/tb_dt_pack.sv
// Directed bench for dt_pack: RAM model plus a queue of expected packed words per frame.
module tb_dt_pack;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  thr;
  logic        res_rd;
  logic [13:0] res_addr;
  logic [7:0]  res_di = 8'd0;
  logic        sti_wr;
  logic [9:0]  sti_addr;
  logic [15:0] sti_do;
  logic        busy;
  logic        done;
  logic [7:0]  max_dist;

  dt_pack dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .thr      (thr),
    .res_rd   (res_rd),
    .res_addr (res_addr),
    .res_di   (res_di),
    .sti_wr   (sti_wr),
    .sti_addr (sti_addr),
    .sti_do   (sti_do),
    .busy     (busy),
    .done     (done),
    .max_dist (max_dist)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:16383];

  always @(posedge clk) begin
    if (res_rd) res_di <= mem[res_addr];
  end

  typedef struct packed {
    logic [9:0]  addr;
    logic [15:0] dat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_word(input int w, input logic [7:0] t);
    logic [15:0] r;
    logic [13:0] a;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      a = 14'(w * 16 + k);
      r[15-k] = (mem[a] >= t);
    end
    return r;
  endfunction

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_res_rd"},   32'(res_rd),   32'd0);
    chk({tag, "_res_addr"}, 32'(res_addr), 32'd0);
    chk({tag, "_sti_wr"},   32'(sti_wr),   32'd0);
    chk({tag, "_sti_addr"}, 32'(sti_addr), 32'd0);
    chk({tag, "_sti_do"},   32'(sti_do),   32'd0);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_done"},     32'(done),     32'd0);
    chk({tag, "_max_dist"}, 32'(max_dist), 32'd0);
  endtask

  // Runs one frame from IDLE/DONE; abort_at >= 0 pulses reset at that cycle instead of finishing.
  task automatic run_frame(input string tag, input logic [7:0] t, input bit toggle, input int abort_at);
    int         cyc;
    int         nwr;
    int         first_wr;
    logic [7:0] mx;
    logic [7:0] mx_exp;
    exp_t       e;
    sb.delete();
    mx = 8'd0;
    for (int w = 0; w < 1024; w++) begin
      e.addr = 10'(w);
      e.dat  = exp_word(w, t);
      sb.push_back(e);
    end
    for (int i = 0; i < 16384; i++) if (mem[i] > mx) mx = mem[i];
`ifdef DT_PACK_MAXDIST_EN
    mx_exp = mx;
`else
    mx_exp = 8'd0;
`endif
    if (done) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    thr   = t;
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    cyc      = 0;
    nwr      = 0;
    first_wr = -1;
    while (!done && cyc < 20000) begin
      if (abort_at >= 0 && cyc == abort_at) begin
        chk({tag, "_pre_abort_busy"}, 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check_zero_outputs({tag, "_abort"});
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_post_abort_busy"}, 32'(busy), 32'd0);
        chk({tag, "_post_abort_rd"}, 32'(res_rd), 32'd0);
        return;
      end
      if (cyc <= 16) begin
        chk({tag, "_res_rd_w0"}, 32'(res_rd), (cyc < 16) ? 32'd1 : 32'd0);
        if (cyc < 16) chk({tag, "_res_addr_w0"}, 32'(res_addr), 32'(cyc));
      end
      if (sti_wr) begin
        if (first_wr < 0) first_wr = cyc;
        nwr++;
        if (sb.size() == 0) begin
          chk({tag, "_sb_extra"}, 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk({tag, "_sti_addr"}, 32'(sti_addr), 32'(e.addr));
          chk({tag, "_sti_do"}, 32'(sti_do), 32'(e.dat));
        end
      end
      if (toggle) start = (cyc < 18000) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_done_cycle"}, 32'(cyc), 32'd18432);
    chk({tag, "_wr_count"}, 32'(nwr), 32'd1024);
    chk({tag, "_first_wr"}, 32'(first_wr), 32'd17);
    chk({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    chk({tag, "_max_dist"}, 32'(max_dist), 32'(mx_exp));
    repeat (3) @(negedge clk);
    chk({tag, "_done_hold"}, 32'(done), 32'd1);
    chk({tag, "_sti_wr_hold"}, 32'(sti_wr), 32'd0);
    chk({tag, "_sti_addr_hold"}, 32'(sti_addr), 32'd1023);
    chk({tag, "_max_hold"}, 32'(max_dist), 32'(mx_exp));
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    thr   = 8'd0;
    for (int i = 0; i < 16384; i++) mem[i] = 8'd0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    reset = 1'b1;
    @(negedge clk);
    check_zero_outputs("idle");

    // Zero image with a single full-scale pixel in the last word, thr=255.
    mem[14'h3FFF] = 8'd255;
    run_frame("thr255", 8'd255, 1'b0, -1);

    // Row 0 cols 0..2 = 4,5,6 at thr=5 -> word 0 = 16'h6000.
    for (int i = 0; i < 16384; i++) mem[i] = 8'd0;
    mem[0] = 8'd4;
    mem[1] = 8'd5;
    mem[2] = 8'd6;
    run_frame("thr5", 8'd5, 1'b0, -1);

    // Random image at thr=0 with start toggling throughout the busy period.
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
    run_frame("thr0_toggle", 8'd0, 1'b1, -1);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_to_idle_done", 32'(done), 32'd0);
    chk("done_to_idle_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    chk("idle_stays_busy", 32'(busy), 32'd0);

    // Odd columns = 3, even = 0 -> 16'h5555; interrupted at word 300, then rerun.
    for (int i = 0; i < 16384; i++) mem[i] = (i % 2 == 1) ? 8'd3 : 8'd0;
    run_frame("abort", 8'd2, 1'b0, 300 * 18 + 8);
    run_frame("thr2", 8'd2, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
